// File: rtl/quadrature_period_diff.sv
// Zero-cross windowed difference of the quadrature SIN/COS accumulators.
// Optional crossing debounce is enabled with QUAD_PERIOD_DIFF_DEBOUNCE_EN.
module quadrature_period_diff #(
  parameter int unsigned RESULT_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH      = 16,
  parameter int unsigned PERIODS          = 1,
  parameter int unsigned TIMEOUT_SAMPLES  = 60000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           CE,
  input  logic signed [RESULT_WIDTH-1:0] SIN_ACC,
  input  logic signed [RESULT_WIDTH-1:0] COS_ACC,
  input  logic                           ZERO_CROSS,
  output logic signed [RESULT_WIDTH-1:0] OUT_SIN_DIFF,
  output logic signed [RESULT_WIDTH-1:0] OUT_COS_DIFF,
  output logic        [COUNT_WIDTH-1:0]  OUT_SAMPLE_COUNT,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic                           OVERRUN,
  output logic                           TIMEOUT
);

  localparam int unsigned EdgeWidth = 8;
  localparam logic [EdgeWidth-1:0] EdgeTarget = EdgeWidth'(2 * PERIODS);
  localparam logic [COUNT_WIDTH-1:0] TimeoutCount = COUNT_WIDTH'(TIMEOUT_SAMPLES);

  if (PERIODS < 1 || PERIODS > 127 || TIMEOUT_SAMPLES == 0 ||
      64'(TIMEOUT_SAMPLES) >= (64'd1 << COUNT_WIDTH) || DEBOUNCE_SAMPLES == 0) begin : g_bad_params
    $error("quadrature_period_diff: illegal parameter combination");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q;
  logic signed [RESULT_WIDTH-1:0] s0_sin_q, s0_cos_q;
  logic                     s0_zc_q;
  logic signed [RESULT_WIDTH-1:0] ref_sin_q, ref_cos_q;
  logic [COUNT_WIDTH-1:0]   sample_cnt_q;
  logic [EdgeWidth-1:0]     edge_cnt_q;
  logic signed [RESULT_WIDTH-1:0] sin_diff_q, cos_diff_q;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     valid_q, overrun_q, timeout_q;

  logic                     gap_ok;
  logic                     accept;
  logic [COUNT_WIDTH-1:0]   cnt_inc;
  logic [EdgeWidth-1:0]     edge_inc;
  logic                     closing;
  logic                     expire;
  logic                     load;
  logic signed [RESULT_WIDTH-1:0] sin_diff, cos_diff;

`ifdef QUAD_PERIOD_DIFF_DEBOUNCE_EN
  localparam int unsigned GapWidth = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [GapWidth-1:0] GapMax = GapWidth'(DEBOUNCE_SAMPLES);

  // Samples since the last accepted crossing, excluding the current one.
  logic [GapWidth-1:0] gap_q;

  assign gap_ok = (32'(gap_q) + 32'd1) >= DEBOUNCE_SAMPLES;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      gap_q <= '0;
    end else if (CE) begin
      if (state_q == StIdle) begin
        if (s0_zc_q) gap_q <= '0;
      end else if (accept) begin
        gap_q <= '0;
      end else if (gap_q < GapMax) begin
        gap_q <= gap_q + GapWidth'(1);
      end
    end
  end
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    accept   = s0_zc_q && gap_ok;
    cnt_inc  = sample_cnt_q + COUNT_WIDTH'(1);
    edge_inc = edge_cnt_q + EdgeWidth'(accept);
    closing  = (state_q == StRun) && accept && (edge_inc == EdgeTarget);
    // A closing crossing on the timeout sample takes precedence.
    expire   = (state_q == StRun) && !closing && (cnt_inc == TimeoutCount);
    load     = CE && closing;
    sin_diff = s0_sin_q - ref_sin_q;
    cos_diff = s0_cos_q - ref_cos_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      s0_sin_q     <= '0;
      s0_cos_q     <= '0;
      s0_zc_q      <= 1'b0;
      ref_sin_q    <= '0;
      ref_cos_q    <= '0;
      sample_cnt_q <= '0;
      edge_cnt_q   <= '0;
      sin_diff_q   <= '0;
      cos_diff_q   <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;

      if (CE) begin
        s0_sin_q <= SIN_ACC;
        s0_cos_q <= COS_ACC;
        s0_zc_q  <= ZERO_CROSS;

        unique case (state_q)
          StIdle: begin
            if (s0_zc_q) begin
              ref_sin_q    <= s0_sin_q;
              ref_cos_q    <= s0_cos_q;
              sample_cnt_q <= '0;
              edge_cnt_q   <= '0;
              state_q      <= StRun;
            end
          end
          StRun: begin
            if (closing) begin
              // Closing snapshot opens the next window with no gap.
              ref_sin_q    <= s0_sin_q;
              ref_cos_q    <= s0_cos_q;
              sample_cnt_q <= '0;
              edge_cnt_q   <= '0;
            end else if (expire) begin
              timeout_q    <= 1'b1;
              sample_cnt_q <= '0;
              edge_cnt_q   <= '0;
              state_q      <= StIdle;
            end else begin
              sample_cnt_q <= cnt_inc;
              edge_cnt_q   <= edge_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Output handshake runs every clock, independent of CE.
      if (load) begin
        sin_diff_q <= sin_diff;
        cos_diff_q <= cos_diff;
        count_q    <= cnt_inc;
        valid_q    <= 1'b1;
        overrun_q  <= valid_q && !OUT_READY;
      end else if (valid_q && OUT_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign OUT_SIN_DIFF     = sin_diff_q;
  assign OUT_COS_DIFF     = cos_diff_q;
  assign OUT_SAMPLE_COUNT = count_q;
  assign OUT_VALID        = valid_q;
  assign OVERRUN          = overrun_q;
  assign TIMEOUT          = timeout_q;

endmodule

// File: tb/tb_quadrature_period_diff.sv
// Randomized + directed bench for quadrature_period_diff against a sample-index reference model.
// Honours QUAD_PERIOD_DIFF_DEBOUNCE_EN in the model when defined.
module tb_quadrature_period_diff;

  localparam int unsigned RW  = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned P   = 1;
  localparam int unsigned TO  = 100;
  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 ce = 1'b0;
  logic                 zc = 1'b0;
  logic                 ready = 1'b0;
  logic signed [RW-1:0] sin_acc = '0;
  logic signed [RW-1:0] cos_acc = '0;
  logic signed [RW-1:0] out_sin, out_cos;
  logic [CW-1:0]        out_cnt;
  logic                 out_valid, overrun, timeout;

  quadrature_period_diff #(
    .RESULT_WIDTH     (RW),
    .COUNT_WIDTH      (CW),
    .PERIODS          (P),
    .TIMEOUT_SAMPLES  (TO),
    .DEBOUNCE_SAMPLES (DEB)
  ) dut (
    .CLK              (clk),
    .RESET            (rst),
    .CE               (ce),
    .SIN_ACC          (sin_acc),
    .COS_ACC          (cos_acc),
    .ZERO_CROSS       (zc),
    .OUT_SIN_DIFF     (out_sin),
    .OUT_COS_DIFF     (out_cos),
    .OUT_SAMPLE_COUNT (out_cnt),
    .OUT_VALID        (out_valid),
    .OUT_READY        (ready),
    .OVERRUN          (overrun),
    .TIMEOUT          (timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_ovr = 0;
  int unsigned n_to = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: windows described by CE-sample indices of the reference,
  // last accepted crossing, and crossing count since the reference.
  int unsigned          m_idx = 0;
  bit                   m_run = 0;
  int unsigned          m_ref_idx = 0;
  int unsigned          m_last_acc = 0;
  int unsigned          m_cross = 0;
  logic signed [RW-1:0] m_ref_sin = '0, m_ref_cos = '0;
  logic signed [RW-1:0] p_sin = '0, p_cos = '0;
  bit                   p_zc = 0;
  bit                   e_valid = 0, e_ovr = 0, e_to = 0;
  logic signed [RW-1:0] e_sin = '0, e_cos = '0;
  logic [CW-1:0]        e_cnt = '0;

  task automatic model_edge();
    bit                   load;
    bit                   acc;
    logic signed [RW-1:0] n_sin, n_cos;
    logic [CW-1:0]        n_cnt;
    load = 0; e_ovr = 0; e_to = 0;
    n_sin = '0; n_cos = '0; n_cnt = '0;
    if (rst) begin
      m_run = 0; p_sin = '0; p_cos = '0; p_zc = 0;
      e_valid = 0; e_sin = '0; e_cos = '0; e_cnt = '0;
      return;
    end
    if (ce) begin
      m_idx++;
      if (!m_run) begin
        if (p_zc) begin
          m_run = 1; m_ref_idx = m_idx; m_last_acc = m_idx; m_cross = 0;
          m_ref_sin = p_sin; m_ref_cos = p_cos;
        end
      end else begin
        acc = p_zc;
`ifdef QUAD_PERIOD_DIFF_DEBOUNCE_EN
        if (m_idx - m_last_acc < DEB) acc = 0;
`endif
        if (acc) begin
          m_cross++;
          m_last_acc = m_idx;
        end
        if (acc && m_cross == 2 * P) begin
          load  = 1;
          n_sin = p_sin - m_ref_sin;
          n_cos = p_cos - m_ref_cos;
          n_cnt = CW'(m_idx - m_ref_idx);
          m_ref_sin = p_sin; m_ref_cos = p_cos; m_ref_idx = m_idx; m_cross = 0;
        end else if (m_idx - m_ref_idx == TO) begin
          e_to = 1;
          m_run = 0;
        end
      end
      p_sin = sin_acc; p_cos = cos_acc; p_zc = zc;
    end
    if (load) begin
      e_ovr = e_valid && !ready;
      e_valid = 1; e_sin = n_sin; e_cos = n_cos; e_cnt = n_cnt;
    end else if (e_valid && ready) begin
      e_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("valid", 64'(out_valid), 64'(e_valid));
    check("overrun", 64'(overrun), 64'(e_ovr));
    check("timeout", 64'(timeout), 64'(e_to));
    if (e_valid) begin
      check("sin_diff", 64'(out_sin), 64'(e_sin));
      check("cos_diff", 64'(out_cos), 64'(e_cos));
      check("count", 64'(out_cnt), 64'(e_cnt));
    end
    if (overrun) n_ovr++;
    if (timeout) n_to++;
  endtask

  task automatic do_reset();
    rst = 1; ce = 0; zc = 0; ready = 0; sin_acc = '0; cos_acc = '0;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sin", 64'(out_sin), 64'd0);
    check("rst_cos", 64'(out_cos), 64'd0);
    check("rst_cnt", 64'(out_cnt), 64'd0);
    rst = 0;
  endtask

  // One CE sample, preceded by 'gaps' CE-low cycles carrying garbage inputs.
  task automatic sample(input logic signed [RW-1:0] s, input logic signed [RW-1:0] c,
                        input bit z, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      ce = 0; sin_acc = RW'($urandom); cos_acc = RW'($urandom); zc = 1'($urandom_range(0, 1));
      step();
    end
    ce = 1; sin_acc = s; cos_acc = c; zc = z;
    step();
  endtask

  task automatic ramp_test(input int gaps);
    do_reset();
    for (int s = 0; s <= 110; s++) begin
      sample(RW'(s * 5), RW'(s * 5), (s == 5 || s == 55 || s == 105), gaps);
      if (s == 105) check("ramp_latency", 64'(out_valid), 64'd0);
      if (s == 106) begin
        check("ramp_valid", 64'(out_valid), 64'd1);
        check("ramp_sin", 64'(out_sin), 64'd500);
        check("ramp_cos", 64'(out_cos), 64'd500);
        check("ramp_cnt", 64'(out_cnt), 64'd100);
      end
    end
    ce = 0; ready = 1;
    step();
    check("ramp_xfer", 64'(out_valid), 64'd0);
    ready = 0;
  endtask

  task automatic wrap_test();
    do_reset();
    ready = 1;
    for (int s = 0; s <= 23; s++) begin
      if (s == 1) sample(RW'(32'h7FFF_FF00), RW'($urandom), 1, 0);
      else if (s == 21) sample(RW'(32'h8000_0100), RW'($urandom), 1, 0);
      else sample(RW'($urandom), RW'($urandom), (s == 10), 0);
      if (s == 22) check("wrap_sin", 64'(out_sin), 64'h0000_0200);
    end
    ready = 0;
  endtask

  task automatic overrun_test();
    int unsigned ovr0;
    do_reset();
    ovr0 = n_ovr;
    for (int s = 0; s <= 50; s++)
      sample(RW'(s * 3), RW'(-s), (s == 2 || s == 12 || s == 22 || s == 30 || s == 47), 0);
    check("ovr_pulses", 64'(n_ovr - ovr0), 64'd1);
    check("ovr_sin", 64'(out_sin), 64'd75);
    check("ovr_cnt", 64'(out_cnt), 64'd25);
    ce = 0; ready = 1;
    step();
    check("ovr_xfer", 64'(out_valid), 64'd0);
    ready = 0;
    step();
    check("ovr_idle", 64'(out_valid), 64'd0);
  endtask

  task automatic timeout_test();
    int unsigned to0;
    do_reset();
    to0 = n_to;
    for (int s = 0; s <= 170; s++) sample(RW'(s), RW'(s), (s == 3 || s == 120 || s == 160), 0);
    check("to_pulses", 64'(n_to - to0), 64'd1);
    check("to_valid", 64'(out_valid), 64'd0);
    for (int s = 171; s <= 201; s++) sample(RW'(s), RW'(s), (s == 200), 0);
    check("to_restart_valid", 64'(out_valid), 64'd1);
    check("to_restart_cnt", 64'(out_cnt), 64'd80);
  endtask

  task automatic debounce_test();
    do_reset();
    for (int s = 0; s <= 112; s++) begin
      sample(RW'(s), RW'(2 * s), (s == 10 || s == 11 || s == 12 || s == 60 || s == 110), 0);
`ifdef QUAD_PERIOD_DIFF_DEBOUNCE_EN
      if (s == 111) check("deb_cnt", 64'(out_cnt), 64'd100);
`else
      if (s == 13) check("nodeb_first_cnt", 64'(out_cnt), 64'd2);
      if (s == 111) check("nodeb_second_cnt", 64'(out_cnt), 64'd98);
`endif
    end
  endtask

  task automatic random_test();
    int zc_tab[3] = '{6, 30, 130};
    int ce_tab[3] = '{1, 2, 3};
    int rd_tab[3] = '{1, 2, 8};
    int zc_den, ce_den, rd_den;
    logic signed [RW-1:0] ws, wc;
    ws = RW'($urandom); wc = RW'($urandom);
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      zc_den = zc_tab[$urandom_range(0, 2)];
      ce_den = ce_tab[$urandom_range(0, 2)];
      rd_den = rd_tab[$urandom_range(0, 2)];
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(0, 4999) == 0) do_reset();
        if ($urandom_range(0, 99) == 0) ws = RW'($urandom);
        else ws = ws + RW'($urandom_range(0, 2000)) - RW'(1000);
        wc = wc + RW'($urandom_range(0, 4000)) - RW'(2000);
        ce = ($urandom_range(0, ce_den - 1) == 0);
        ready = ($urandom_range(0, rd_den - 1) == 0);
        zc = ($urandom_range(0, zc_den - 1) == 0);
        sin_acc = ws; cos_acc = wc;
        step();
      end
    end
  endtask

  initial begin
    ramp_test(0);
    ramp_test(2);
    wrap_test();
    overrun_test();
    timeout_test();
    debounce_test();
    random_test();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
